cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports mem_read, mem_write  input  1 each  CPU-side request strobes, held until mem_resp.
REQ-004 SHALL have port mem_resp  output  1  request-complete pulse to CPU.
REQ-005 SHALL have ports hit, valid, dirty  input  1 each  datapath status: tag match, valid of selected way, dirty of LRU way.
REQ-006 SHALL have ports pmem_read, pmem_write  output  1 each  and pmem_resp  input  1  physical-memory handshake.
REQ-007 SHALL have outputs, 1 bit each, to the datapath: way_sel_method (0=hit way, 1=LRU way), load_line_data, load_valid, load_wdata_reg, load_dirty, load_LRU, line_datain_sel (0=pmem_rdata, 1=modified line), valid_in, dirty_in, address_sel (0=request line address, 1=write-back address).
REQ-008 SHALL, when CACHE_PERF_EN is defined, add outputs hit_count, miss_count, wb_count  output  32 each.

Function
REQ-009 SHALL implement states IDLE, WRITEBACK, ALLOCATE; all outputs are decoded from state and inputs (Moore/Mealy mix); every output defaults to 0 unless set below.
REQ-010 SHALL define real_hit = hit AND valid, evaluated in IDLE with way_sel_method=0.
REQ-011 IDLE, no request: all outputs 0, stay IDLE; pmem_resp ignored.
REQ-012 IDLE, mem_read and real_hit: mem_resp=1, load_LRU=1 in the same cycle (0-cycle added latency); stay IDLE.
REQ-013 IDLE, mem_write and real_hit: mem_resp=1, load_LRU=1, load_line_data=1, line_datain_sel=1, load_dirty=1, dirty_in=1; stay IDLE.
REQ-014 mem_read and mem_write both asserted SHALL be handled as a write.
REQ-015 IDLE, request and not real_hit: way_sel_method=1; if dirty=1 assert load_wdata_reg=1 and go WRITEBACK, else go ALLOCATE; mem_resp=0.
REQ-016 WRITEBACK: way_sel_method=1, address_sel=1, pmem_write=1 held until pmem_resp; on pmem_resp go ALLOCATE.
REQ-017 ALLOCATE: way_sel_method=1, address_sel=0, pmem_read=1 held until pmem_resp; on pmem_resp assert load_line_data=1, line_datain_sel=0, load_valid=1, valid_in=1, load_dirty=1, dirty_in=0, go IDLE.
REQ-018 After ALLOCATE, the request SHALL be re-serviced in IDLE as a hit; miss latency = pmem latencies + 2 cycles (one per state transition plus IDLE retry).
REQ-019 pmem_read and pmem_write SHALL never be asserted in the same cycle.
REQ-020 Request deasserted mid-miss: current pmem transaction SHALL complete and the line be filled; no mem_resp issued.
REQ-021 load_LRU SHALL never assert outside IDLE.

Reset
REQ-022 rst=1 SHALL force state IDLE at the next edge, including mid-WRITEBACK/ALLOCATE; pmem_read, pmem_write deassert the cycle after.
REQ-023 All outputs SHALL be 0 while rst=1; counters reset to 0.

Configuration
REQ-024 CACHE_PERF_EN defined: miss_count +1 on each IDLE->WRITEBACK/ALLOCATE transition; wb_count +1 on WRITEBACK exit; hit_count +1 on mem_resp only if no miss occurred for that request (internal miss_pending flag, set on miss, cleared on mem_resp or rst).
REQ-025 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-026 CACHE_PERF_EN undefined: counter ports and logic absent; FSM behaviour identical.

Verification
REQ-027 Read hit: mem_read=1, hit=1, valid=1 -> mem_resp=1, load_LRU=1 same cycle; hit_count 0->1.
REQ-028 Clean read miss: hit=0, dirty=0 -> ALLOCATE, pmem_read=1; pmem_resp after 5 cycles -> load_line_data=1, valid_in=1, dirty_in=0; next cycle with hit=1 mem_resp=1; miss_count=1, hit_count=0.
REQ-029 Dirty write miss: mem_write=1, hit=0, dirty=1 -> load_wdata_reg=1, WRITEBACK with address_sel=1, pmem_write=1; pmem_resp -> ALLOCATE; fill; write hit sets dirty_in=1, line_datain_sel=1; wb_count=1.
REQ-030 rst=1 asserted in WRITEBACK with pmem_write=1 -> IDLE next edge, pmem_write=0, all counters 0.
REQ-031 Request dropped in ALLOCATE -> pmem_resp still fills line, mem_resp stays 0, FSM returns IDLE.
REQ-032 mem_read=mem_write=1 with real hit -> write signals (load_dirty=1, dirty_in=1) asserted.

Source files
------------

// File: rtl/cache_control_if.sv
// cache_control_if: groups the CPU request, datapath status/control and
// physical-memory handshake signals of the cache controller.
// The slave modport is the controller's view; master is the environment's view.
interface cache_control_if;
    // CPU side
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    // Datapath status
    logic hit;
    logic valid;
    logic dirty;
    // Physical memory handshake
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;
    // Datapath control
    logic way_sel_method;
    logic load_line_data;
    logic load_valid;
    logic load_wdata_reg;
    logic load_dirty;
    logic load_LRU;
    logic line_datain_sel;
    logic valid_in;
    logic dirty_in;
    logic address_sel;

    modport slave (
        input  mem_read, mem_write, hit, valid, dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write, way_sel_method,
               load_line_data, load_valid, load_wdata_reg, load_dirty,
               load_LRU, line_datain_sel, valid_in, dirty_in, address_sel
    );

    modport master (
        output mem_read, mem_write, hit, valid, dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, way_sel_method,
               load_line_data, load_valid, load_wdata_reg, load_dirty,
               load_LRU, line_datain_sel, valid_in, dirty_in, address_sel
    );
endinterface

// File: rtl/cache_control.sv
// cache_control: write-back cache controller FSM (IDLE / WRITEBACK / ALLOCATE).
// Hits complete in IDLE with no added latency; misses optionally write back
// the dirty LRU line, then allocate, then retry in IDLE where they hit.
// Optional feature macro: CACHE_PERF_EN adds saturating 32-bit hit, miss and
// write-back counters.
module cache_control (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_if.slave       bus
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
    output logic [31:0]          wb_count
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic req_s;
    logic real_hit_s;

    assign req_s      = bus.mem_read | bus.mem_write;
    assign real_hit_s = bus.hit & bus.valid;

    // Next-state and output decode; everything forced low while in reset.
    always_comb begin
        state_d             = state_q;
        bus.mem_resp        = 1'b0;
        bus.pmem_read       = 1'b0;
        bus.pmem_write      = 1'b0;
        bus.way_sel_method  = 1'b0;
        bus.load_line_data  = 1'b0;
        bus.load_valid      = 1'b0;
        bus.load_wdata_reg  = 1'b0;
        bus.load_dirty      = 1'b0;
        bus.load_LRU        = 1'b0;
        bus.line_datain_sel = 1'b0;
        bus.valid_in        = 1'b0;
        bus.dirty_in        = 1'b0;
        bus.address_sel     = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        if (real_hit_s) begin
                            bus.mem_resp = 1'b1;
                            bus.load_LRU = 1'b1;
                            // A simultaneous read and write is serviced as a write.
                            if (bus.mem_write) begin
                                bus.load_line_data  = 1'b1;
                                bus.line_datain_sel = 1'b1;
                                bus.load_dirty      = 1'b1;
                                bus.dirty_in        = 1'b1;
                            end else begin
                                bus.load_line_data  = 1'b0;
                            end
                            state_d = IDLE;
                        end else begin
                            bus.way_sel_method = 1'b1;
                            if (bus.dirty) begin
                                bus.load_wdata_reg = 1'b1;
                                state_d            = WRITEBACK;
                            end else begin
                                state_d            = ALLOCATE;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WRITEBACK: begin
                    bus.way_sel_method = 1'b1;
                    bus.address_sel    = 1'b1;
                    bus.pmem_write     = 1'b1;
                    if (bus.pmem_resp) begin
                        state_d = ALLOCATE;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
                ALLOCATE: begin
                    bus.way_sel_method = 1'b1;
                    bus.pmem_read      = 1'b1;
                    // The fill completes even if the CPU dropped its request.
                    if (bus.pmem_resp) begin
                        bus.load_line_data = 1'b1;
                        bus.load_valid     = 1'b1;
                        bus.valid_in       = 1'b1;
                        bus.load_dirty     = 1'b1;
                        state_d            = IDLE;
                    end else begin
                        state_d            = ALLOCATE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CACHE_PERF_EN
    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [31:0] hit_count_q,  hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q,   wb_count_d;
    logic        miss_pending_q, miss_pending_d;
    logic        miss_event_s;
    logic        wb_done_s;

    assign miss_event_s = (state_q == IDLE) && (state_d != IDLE);
    assign wb_done_s    = (state_q == WRITEBACK) && bus.pmem_resp && !rst;

    // Counter updates; a response only counts as a hit if its request never missed.
    always_comb begin
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        wb_count_d     = wb_count_q;
        miss_pending_d = miss_pending_q;
        if (miss_event_s) begin
            miss_count_d   = sat_inc(miss_count_q);
            miss_pending_d = 1'b1;
        end else begin
            miss_count_d   = miss_count_q;
        end
        if (wb_done_s) begin
            wb_count_d = sat_inc(wb_count_q);
        end else begin
            wb_count_d = wb_count_q;
        end
        if (bus.mem_resp) begin
            if (!miss_pending_q) begin
                hit_count_d = sat_inc(hit_count_q);
            end else begin
                hit_count_d = hit_count_q;
            end
            miss_pending_d = 1'b0;
        end else begin
            hit_count_d = hit_count_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q    <= 32'd0;
            miss_count_q   <= 32'd0;
            wb_count_q     <= 32'd0;
            miss_pending_q <= 1'b0;
        end else begin
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            wb_count_q     <= wb_count_d;
            miss_pending_q <= miss_pending_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed and randomized checks of cache_control against a
// transaction-level reference model (a queue of outstanding memory operations).
// Counter checks are compiled in only when CACHE_PERF_EN is defined.
module tb_cache_control;

    logic clk;
    logic rst;
    cache_control_if bus_if();

`ifdef CACHE_PERF_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_control dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
`ifdef CACHE_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count),
        .wb_count(wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests_run;
    int unsigned tests_failed;

    // Observed output vector, fixed field order shared with the model.
    logic [12:0] obs;
    assign obs = {bus_if.mem_resp, bus_if.pmem_read, bus_if.pmem_write,
                  bus_if.way_sel_method, bus_if.load_line_data, bus_if.load_valid,
                  bus_if.load_wdata_reg, bus_if.load_dirty, bus_if.load_LRU,
                  bus_if.line_datain_sel, bus_if.valid_in, bus_if.dirty_in,
                  bus_if.address_sel};

    // Reference model: outstanding memory operations for the current miss.
    localparam int OP_WB   = 0;
    localparam int OP_FILL = 1;
    int          ops[$];
    logic [31:0] m_hits, m_misses, m_wbs;
    bit          m_miss_pend;

    function automatic logic [31:0] m_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [12:0] m_expect();
        logic resp, pr, pw, way, lld, lv, lwd, ldy, lru, dsel, vin, din, asel;
        logic rq, wr;
        {resp, pr, pw, way, lld, lv, lwd, ldy, lru, dsel, vin, din, asel} = 13'd0;
        rq = bus_if.mem_read | bus_if.mem_write;
        wr = bus_if.mem_write;
        if (rst) begin
            resp = 1'b0;
        end else if (ops.size() == 0) begin
            if (rq && bus_if.hit && bus_if.valid) begin
                resp = 1'b1; lru = 1'b1;
                if (wr) begin lld = 1'b1; dsel = 1'b1; ldy = 1'b1; din = 1'b1; end
            end else if (rq) begin
                way = 1'b1; lwd = bus_if.dirty;
            end
        end else if (ops[0] == OP_WB) begin
            way = 1'b1; asel = 1'b1; pw = 1'b1;
        end else begin
            way = 1'b1; pr = 1'b1;
            if (bus_if.pmem_resp) begin lld = 1'b1; lv = 1'b1; vin = 1'b1; ldy = 1'b1; end
        end
        return {resp, pr, pw, way, lld, lv, lwd, ldy, lru, dsel, vin, din, asel};
    endfunction

    function automatic void m_advance();
        if (rst) begin
            ops.delete();
            m_hits = 32'd0; m_misses = 32'd0; m_wbs = 32'd0; m_miss_pend = 1'b0;
        end else if (ops.size() == 0) begin
            if (bus_if.mem_read || bus_if.mem_write) begin
                if (bus_if.hit && bus_if.valid) begin
                    if (!m_miss_pend) m_hits = m_sat(m_hits);
                    m_miss_pend = 1'b0;
                end else begin
                    m_misses = m_sat(m_misses);
                    m_miss_pend = 1'b1;
                    if (bus_if.dirty) ops.push_back(OP_WB);
                    ops.push_back(OP_FILL);
                end
            end
        end else if (bus_if.pmem_resp) begin
            if (ops[0] == OP_WB) m_wbs = m_sat(m_wbs);
            void'(ops.pop_front());
        end
    endfunction

    task automatic set_in(input logic rd, input logic wr, input logic h,
                          input logic v, input logic d, input logic pr);
        bus_if.mem_read  = rd;
        bus_if.mem_write = wr;
        bus_if.hit       = h;
        bus_if.valid     = v;
        bus_if.dirty     = d;
        bus_if.pmem_resp = pr;
    endtask

    // Model consumes the current inputs, then the DUT clocks them in.
    task automatic end_cycle();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            tests_run++;
            if (obs !== 13'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got %b expected %b", obs, 13'd0);
            end
            end_cycle();
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL idle_no_request: got %b expected %b", obs, 13'd0);
        end
`ifdef CACHE_PERF_EN
        tests_run++;
        if ({hit_count, miss_count, wb_count} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, wb_count);
        end
`endif
        end_cycle();
    endtask

    task automatic test_read_hit();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.mem_resp !== 1'b1 || bus_if.load_LRU !== 1'b1 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL read_hit: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CACHE_PERF_EN
        @(negedge clk);
        tests_run++;
        if (hit_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL read_hit_count: got %0d expected 1", hit_count);
        end
        end_cycle();
`endif
    endtask

    task automatic test_clean_read_miss();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.way_sel_method !== 1'b1 || bus_if.mem_resp !== 1'b0 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL clean_miss_idle: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        for (int i = 0; i < 5; i++) begin
            bus_if.pmem_resp = (i == 4);
            @(negedge clk);
            tests_run++;
            if (bus_if.pmem_read !== 1'b1 || bus_if.pmem_write !== 1'b0 || obs !== m_expect()) begin
                tests_failed++;
                $display("FAIL clean_miss_alloc%0d: got %b expected %b", i, obs, m_expect());
            end
            end_cycle();
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.mem_resp !== 1'b1 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL clean_miss_retry: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CACHE_PERF_EN
        @(negedge clk);
        tests_run++;
        if (miss_count !== 32'd1 || hit_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL clean_miss_counts: got miss %0d hit %0d expected miss 1 hit 1", miss_count, hit_count);
        end
        end_cycle();
`endif
    endtask

    task automatic test_dirty_write_miss();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.load_wdata_reg !== 1'b1 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL dirty_miss_idle: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        for (int i = 0; i < 3; i++) begin
            bus_if.pmem_resp = (i == 2);
            @(negedge clk);
            tests_run++;
            if (bus_if.pmem_write !== 1'b1 || bus_if.address_sel !== 1'b1 || obs !== m_expect()) begin
                tests_failed++;
                $display("FAIL dirty_miss_wb%0d: got %b expected %b", i, obs, m_expect());
            end
            end_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            bus_if.pmem_resp = (i == 1);
            @(negedge clk);
            tests_run++;
            if (bus_if.pmem_read !== 1'b1 || bus_if.address_sel !== 1'b0 || obs !== m_expect()) begin
                tests_failed++;
                $display("FAIL dirty_miss_alloc%0d: got %b expected %b", i, obs, m_expect());
            end
            end_cycle();
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.dirty_in !== 1'b1 || bus_if.line_datain_sel !== 1'b1 || bus_if.mem_resp !== 1'b1) begin
            tests_failed++;
            $display("FAIL dirty_miss_write_hit: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CACHE_PERF_EN
        @(negedge clk);
        tests_run++;
        if (wb_count !== 32'd1 || miss_count !== m_misses) begin
            tests_failed++;
            $display("FAIL dirty_miss_counts: got wb %0d miss %0d expected wb 1 miss %0d", wb_count, miss_count, m_misses);
        end
        end_cycle();
`endif
    endtask

    task automatic test_reset_mid_writeback();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end_cycle();
        end_cycle();
        @(negedge clk);
        tests_run++;
        if (bus_if.pmem_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wb_pre: got pmem_write %b expected 1", bus_if.pmem_write);
        end
        m_advance();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL rst_wb_during: got %b expected %b", obs, 13'd0);
        end
        end_cycle();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL rst_wb_after: got %b expected %b", obs, 13'd0);
        end
`ifdef CACHE_PERF_EN
        tests_run++;
        if ({hit_count, miss_count, wb_count} !== 96'd0) begin
            tests_failed++;
            $display("FAIL rst_wb_counters: got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, wb_count);
        end
`endif
        end_cycle();
    endtask

    task automatic test_drop_in_allocate();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end_cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.pmem_read !== 1'b1 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL drop_alloc_hold: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        bus_if.pmem_resp = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus_if.load_line_data !== 1'b1 || bus_if.mem_resp !== 1'b0 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL drop_alloc_fill: got %b expected %b", obs, m_expect());
        end
        end_cycle();
        bus_if.pmem_resp = 1'b0;
        @(negedge clk);
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL drop_alloc_idle: got %b expected %b", obs, 13'd0);
        end
        end_cycle();
    endtask

    task automatic test_read_write_both();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus_if.load_dirty !== 1'b1 || bus_if.dirty_in !== 1'b1 || obs !== m_expect()) begin
            tests_failed++;
            $display("FAIL rd_wr_both: got %b expected %b", obs, m_expect());
        end
        end_cycle();
    endtask

    task automatic test_random();
        logic [12:0] exp_v;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            @(negedge clk);
            exp_v = m_expect();
            tests_run++;
            if (obs !== exp_v || (bus_if.pmem_read & bus_if.pmem_write) !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, obs, exp_v);
            end
`ifdef CACHE_PERF_EN
            tests_run++;
            if (hit_count !== m_hits || miss_count !== m_misses || wb_count !== m_wbs) begin
                tests_failed++;
                $display("FAIL random_counters%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         i, hit_count, miss_count, wb_count, m_hits, m_misses, m_wbs);
            end
`endif
            end_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_hits = 32'd0; m_misses = 32'd0; m_wbs = 32'd0; m_miss_pend = 1'b0;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_reset_mid_writeback();
        test_drop_in_allocate();
        test_read_write_both();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
